// File: rtl/ex_alu_unit_pkg.sv
// Shared constants for the EX-stage ALU: control codes from the ALU control
// decoder and the state encoding of the execute unit.
package ex_alu_unit_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;
   localparam logic [2:0] ALU_MUL = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } ex_state_t;

endpackage

// File: rtl/ex_alu_unit_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per step, WIDTH steps,
// low WIDTH bits of the unsigned product presented with done_o.
module seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             i_start,
   input  logic             i_step,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_mcand,
   input  logic [WIDTH-1:0] i_mplier,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] w_acc_next;

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign o_product  = w_acc_next;
   assign o_done     = i_step && (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_mcand  <= i_mcand;
         r_mplier <= i_mplier;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (i_step) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ex_alu_unit.sv
// EX-stage ALU: single-cycle ADD/SUB/AND/OR with a registered result, plus a
// multi-cycle MUL that stalls upstream through busy_o.
//
// state   | meaning
// ST_IDLE | accepting ops; single-cycle results retire here
// ST_MUL  | shift-add multiply running, busy_o high, valid_i ignored
module ex_alu_unit
   import ex_alu_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [2:0]       ALU_Ctrl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o
);

   ex_state_t        r_state;
   ex_state_t        w_state_next;
   logic [WIDTH-1:0] w_alu_result;
   logic             w_is_mul;
   logic             w_accept;
   logic             w_mul_start;
   logic             w_mul_step;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_product;
   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             r_zero;

   assign w_is_mul    = (ALU_Ctrl_i == ALU_MUL);
   assign w_accept    = (r_state == ST_IDLE) && valid_i && !flush_i;
   assign w_mul_start = w_accept && w_is_mul;
   assign w_mul_step  = (r_state == ST_MUL) && !flush_i;

   always_comb begin
      w_alu_result = '0;
      case (ALU_Ctrl_i)
         ALU_ADD: w_alu_result = data1_i + data2_i;
         ALU_SUB: w_alu_result = data1_i - data2_i;
         ALU_AND: w_alu_result = data1_i & data2_i;
         ALU_OR:  w_alu_result = data1_i | data2_i;
         default: w_alu_result = '0;
      endcase
   end

   seq_multiplier #(.WIDTH(WIDTH)) u_mul (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_start   (w_mul_start),
      .i_step    (w_mul_step),
      .i_clear   (flush_i),
      .i_mcand   (data1_i),
      .i_mplier  (data2_i),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (flush_i) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
            ST_MUL:  if (w_mul_done)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o = (r_state == ST_MUL);
   end

   // Result registers; flush kills the pulse but keeps the last result visible.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_zero  <= 1'b1;
      end else if (flush_i) begin
         r_valid <= 1'b0;
      end else if (w_accept && !w_is_mul) begin
         r_valid <= 1'b1;
         r_data  <= w_alu_result;
         r_zero  <= (w_alu_result == '0);
      end else if (w_mul_done) begin
         r_valid <= 1'b1;
         r_data  <= w_mul_product;
         r_zero  <= (w_mul_product == '0);
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign valid_o = r_valid;
   assign data_o  = r_data;
   assign zero_o  = r_zero;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit: directed ops push expected results, a
// negedge monitor pops and compares whenever valid_o is seen.
module tb_ex_alu_unit;

   localparam int WIDTH = 32;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic             valid_i = 1'b0;
   logic [2:0]       ALU_Ctrl_i = 3'b000;
   logic [WIDTH-1:0] data1_i = '0;
   logic [WIDTH-1:0] data2_i = '0;
   logic             flush_i = 1'b0;
   logic             busy_o;
   logic             valid_o;
   logic [WIDTH-1:0] data_o;
   logic             zero_o;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             zero;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   ex_alu_unit #(.WIDTH(WIDTH)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .ALU_Ctrl_i (ALU_Ctrl_i),
      .data1_i    (data1_i),
      .data2_i    (data2_i),
      .flush_i    (flush_i),
      .busy_o     (busy_o),
      .valid_o    (valid_o),
      .data_o     (data_o),
      .zero_o     (zero_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every valid_o pulse must match the oldest expected result.
   always @(negedge clk_i) begin
      if (rst_i && valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid: got data 0x%0h, expected no pulse", data_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result_data", {32'h0, data_o}, {32'h0, e.data});
            chk("result_zero", {63'h0, zero_o}, {63'h0, e.zero});
         end
      end
   end

   // Present one op at a negedge; valid_i stays high until idle() is called.
   task automatic issue(input logic [2:0] code, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit push,
                        input logic [WIDTH-1:0] exp_data);
      exp_t e;
      @(negedge clk_i);
      valid_i    = 1'b1;
      ALU_Ctrl_i = code;
      data1_i    = a;
      data2_i    = b;
      if (push) begin
         e.data = exp_data;
         e.zero = (exp_data == '0);
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_i);
         valid_i = 1'b0;
      end
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 60) begin
         @(negedge clk_i);
         k++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int busy_cnt;
      logic [WIDTH-1:0] held;

      repeat (2) @(negedge clk_i);
      chk("reset_busy",  {63'h0, busy_o},  64'd0);
      chk("reset_valid", {63'h0, valid_o}, 64'd0);
      chk("reset_data",  {32'h0, data_o},  64'd0);
      chk("reset_zero",  {63'h0, zero_o},  64'd1);
      rst_i = 1'b1;

      // ADD, then back-to-back SUBs
      issue(3'b000, 32'd5, 32'd7, 1, 32'd12);
      idle(1);
      chk("add_busy", {63'h0, busy_o}, 64'd0);
      issue(3'b010, 32'd3, 32'd5, 1, 32'hFFFF_FFFE);
      issue(3'b010, 32'd9, 32'd9, 1, 32'd0);
      chk("b2b_valid_first", {63'h0, valid_o}, 64'd1);
      idle(1);
      chk("b2b_valid_second", {63'h0, valid_o}, 64'd1);
      idle(2);

      // MUL 6*7 with ignored ADD pulses while busy
      issue(3'b111, 32'd6, 32'd7, 1, 32'd42);
      busy_cnt = 0;
      repeat (40) begin
         @(negedge clk_i);
         if (busy_o) busy_cnt++;
         valid_i    = busy_o && (busy_cnt == 3 || busy_cnt == 10 || busy_cnt == 20);
         ALU_Ctrl_i = 3'b000;
         data1_i    = 32'd100;
         data2_i    = 32'd1;
      end
      chk("mul_busy_cycles", 64'(busy_cnt), 64'd32);
      drain("mul_drain");

      issue(3'b111, 32'hFFFF_FFFF, 32'd2, 1, 32'hFFFF_FFFE);
      idle(1);
      drain("mul_wrap_drain");

      // Flush mid-MUL
      held = data_o;
      issue(3'b111, 32'd3, 32'd4, 0, '0);
      idle(9);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      chk("flush_busy", {63'h0, busy_o}, 64'd0);
      chk("flush_hold", {32'h0, data_o}, {32'h0, held});
      idle(40);
      issue(3'b000, 32'd1, 32'd1, 1, 32'd2);
      idle(1);
      drain("flush_add_drain");

      // Async reset mid-MUL
      issue(3'b111, 32'd5, 32'd5, 0, '0);
      idle(15);
      #2 rst_i = 1'b0;
      #1;
      chk("areset_busy",  {63'h0, busy_o},  64'd0);
      chk("areset_valid", {63'h0, valid_o}, 64'd0);
      chk("areset_data",  {32'h0, data_o},  64'd0);
      chk("areset_zero",  {63'h0, zero_o},  64'd1);
      @(negedge clk_i);
      rst_i = 1'b1;
      idle(40);

      // Undefined code, AND, OR
      issue(3'b110, 32'd5, 32'd3, 1, 32'd0);
      issue(3'b100, 32'h0000_F0F0, 32'h0000_FF00, 1, 32'h0000_F000);
      issue(3'b101, 32'h0000_F0F0, 32'h0000_FF00, 1, 32'h0000_FFF0);
      idle(1);
      drain("logic_drain");
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_alu_unit.md
Name: ex_alu_unit

Overview:
- Execute-stage datapath unit directly downstream of the ALU control decoder.
- Consumes the 3-bit ALU control code and the two EX operands, then produces a registered result.
- Single-cycle ops (ADD/SUB/AND/OR) complete in 1 clock.
- MUL (code 3'b111) runs an iterative shift-add multiplier over WIDTH clocks and stalls the pipeline via busy_o.

Parameters:
- WIDTH, 32, operand/result width in bits; MUL iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-low reset
- valid_i  input  1  operation presented this cycle
- ALU_Ctrl_i  input  3  ALU control code from ALU control decoder
- data1_i  input  WIDTH  operand A (rs / multiplicand)
- data2_i  input  WIDTH  operand B (rt or sign-extended immediate / multiplier)
- flush_i  input  1  synchronous abort of any in-flight operation
- busy_o  output  1  MUL in progress; upstream must hold its stage
- valid_o  output  1  one-cycle pulse, data_o/zero_o valid
- data_o  output  WIDTH  result
- zero_o  output  1  data_o == 0, registered with data_o

Behaviour:
- Reset (rst_i low, asynchronous): state=IDLE; busy_o=0; valid_o=0; data_o=0; zero_o=1; counter, accumulator and shift registers cleared.
- Codes:
  - 000 ADD: A+B mod 2^WIDTH.
  - 010 SUB: A-B mod 2^WIDTH.
  - 100 AND.
  - 101 OR.
  - 111 MUL: low WIDTH bits of unsigned A*B.
  - 001/011/110: result 0, single-cycle, valid_o still pulses.
- No overflow or carry flags.
- States: IDLE, MUL.
- IDLE:
  - valid_i=1 with non-MUL code: at that edge data_o <= result, zero_o updated, valid_o <= 1; stay IDLE. Back-to-back accepts every cycle are allowed.
  - valid_i=1 with MUL code: at that edge mcand <= A, mplier <= B, acc <= 0, cnt <= 0, valid_o <= 0; go to MUL.
  - valid_i=0: valid_o <= 0; data_o and zero_o hold.
- MUL, each edge:
  - acc <= acc + (mplier[0] ? mcand : 0).
  - mcand <= mcand << 1 (truncated to WIDTH).
  - mplier <= mplier >> 1.
  - cnt <= cnt + 1.
- MUL, edge where cnt == WIDTH-1: data_o <= acc_next, zero_o updated, valid_o <= 1; go to IDLE.
- MUL latency: valid_o is high in the cycle after the WIDTH-th edge following the accepting edge. No early termination, so latency is fixed regardless of operand values.
- busy_o = (state == MUL), combinational from the state register. It is high for exactly WIDTH cycles per MUL.
- valid_i is ignored while busy_o=1. Upstream holds its inputs, and the unit does not re-sample them.
- A MUL accepted on the cycle after a MUL completes is legal. valid_o=1 from the first MUL coexists with the new accept edge.
- flush_i (synchronous, priority over valid_i): at the edge, state <= IDLE, valid_o <= 0, cnt <= 0; data_o and zero_o hold. An aborted MUL produces no valid_o pulse. flush_i with valid_i in IDLE discards the op.
- Reset mid-MUL: immediate return to reset values; no valid_o pulse afterwards.
- cnt width is clog2(WIDTH), sized so WIDTH-1 is representable; no wrap within one MUL.

Decomposition:
- Shared package holds:
  - localparams for ALU control codes: ALU_ADD=3'b000, ALU_SUB=3'b010, ALU_AND=3'b100, ALU_OR=3'b101, ALU_MUL=3'b111.
  - the state encoding (IDLE=1'b0, MUL=1'b1).
- The ALU control decoder uses the same code constants.
- One sub-module, seq_multiplier: holds mcand/mplier/acc/cnt with start/done handshake. The parent handles code decode, the single-cycle ALU, the output registers and flush.

Test Plan:
- Reset then ADD: rst_i low 2 cycles, release; ADD A=5,B=7 -> next cycle valid_o=1, data_o=12, zero_o=0, busy_o never high.
- SUB wrap and zero:
  - SUB A=3,B=5 -> data_o=32'hFFFFFFFE.
  - SUB A=9,B=9 -> data_o=0, zero_o=1.
  - Both ops issued back-to-back, with valid_o high on two consecutive cycles.
- MUL latency:
  - MUL A=6,B=7 -> busy_o high exactly 32 cycles.
  - valid_o pulses once with data_o=42.
  - valid_i pulses carrying ADD during busy are ignored.
  - MUL A=32'hFFFFFFFF,B=2 -> data_o=32'hFFFFFFFE.
- Flush mid-MUL: MUL A=3,B=4, assert flush_i on cycle 10 -> busy_o low next cycle, no valid_o, data_o keeps prior value; following ADD 1+1 -> data_o=2.
- Async reset mid-MUL: drop rst_i at cycle 15 of a MUL between clock edges -> busy_o=0, data_o=0, zero_o=1 immediately; no valid_o after release.
- Undefined code and AND/OR: code 3'b110 with A=5,B=3 -> valid_o=1, data_o=0. AND 0xF0F0&0xFF00 -> 0xF000. OR -> 0xFFF0.
